mem_region_ctrl: RTL and testbench
==================================

// Module: mem_region_ctrl
// PURPOSE
//  Parametrised memory-region controller between the CPU/DMA bus and the GBA on-chip BRAMs (BIOS, IWRAM, VRAM, palette, OAM, ...).
//  Decodes NUM_REGIONS address windows for two ports: the bus port (read/write, per-region wait states) and the gfx port (read-only, 1-cycle).
//  Enforces read-only regions. Flags unmapped or illegal accesses. Drives flattened BRAM port A/B buses.
// PARAMETERS
//  NUM_REGIONS  5                    number of decoded windows (1..8)
//  MEM_AW       16                   word-address width driven to every BRAM
//  WS_W         3                    width of the wait-state counter
//  REGION_BASE  gba_mem_pkg default  [NUM_REGIONS][32] byte base address, 4-byte aligned
//  REGION_SIZE  gba_mem_pkg default  [NUM_REGIONS][32] byte size; hit iff (addr - base) < size
//  REGION_WS    gba_mem_pkg default  [NUM_REGIONS][WS_W] extra bus wait states
//  REGION_RO    gba_mem_pkg default  [NUM_REGIONS] 1 = bus writes are dropped
// PORTS
//  clock        in   1            single clock
//  reset_n      in   1            asynchronous, active-low reset
//  bus_req      in   1            bus access request; held with all bus_* inputs while bus_pause=1
//  bus_addr     in   32           byte address
//  bus_wdata    in   32           write data, already lane-aligned by the CPU
//  bus_size     in   2            MEM_SIZE_BYTE/HALF/WORD
//  bus_write    in   1            1 = write
//  bus_rdata    out  32           read data
//  bus_pause    out  1            stall to CPU/DMA
//  bus_fault    out  1            1-cycle pulse: unmapped access or write to an RO region
//  gfx_addr     in   32           graphics read byte address
//  gfx_rdata    out  32           graphics read data, 1 cycle after gfx_addr
//  mem_en_a     out  NUM_REGIONS  port-A enable per region
//  mem_we_a     out  4            port-A byte write enables (shared by all regions)
//  mem_addr_a   out  MEM_AW       port-A word address ((addr - base) >> 2)
//  mem_wdata_a  out  32           port-A write data
//  mem_rdata_a  in   NUM_REGIONS*32  port-A read data, region r at [32r+:32]
//  mem_en_b     out  NUM_REGIONS  port-B enable per region
//  mem_addr_b   out  MEM_AW       port-B word address
//  mem_rdata_b  in   NUM_REGIONS*32  port-B read data
// BEHAVIOUR
//  Reset (while reset_n=0):
//   - State is IDLE; counter is 0.
//   - bus_pause, bus_fault, mem_en_a/b, mem_we_a are all 0.
//   - bus_rdata and gfx_rdata are 32'hFFFF_FFFF.
//   - A write in flight is abandoned and never committed.
//  Decode:
//   - Lowest-index region hit wins. No hit = unmapped.
//  Request accepted in cycle N (IDLE and bus_req=1); w = REGION_WS[r].
//  FSM: IDLE, RWAIT, WWAIT, WRITE.
//  IDLE:
//   - bus_pause = bus_req & ~bus_write & (w != 0), combinational.
//   - Read, w=0: mem_en_a[r] asserted in cycle N from bus_addr; stay IDLE.
//   - Read, w>0: counter loads w-1; go to RWAIT.
//   - Write: latch addr/size/wdata/region. Go to WWAIT with counter w-1 if w>0, else WRITE.
//   - Unmapped, or write to an RO region: no enable; stay IDLE.
//  RWAIT:
//   - bus_pause = (counter != 0); counter decrements each cycle.
//   - At counter 0: mem_en_a[r] asserted with the held bus_addr, then IDLE.
//  WWAIT:
//   - bus_pause = 1; counter decrements. At 0, go to WRITE.
//  WRITE:
//   - bus_pause = 1; mem_en_a[r]=1; mem_we_a = byte lanes from latched addr[1:0]/size, latched wdata. Then IDLE.
//   - Byte lanes: byte=1 lane, half=lanes {1,0} or {3,2} by addr[1], word=all 4.
//  Timing:
//   - Read data: bus_rdata registered from mem_rdata_a of the region selected in the issue cycle.
//   - Read data is valid the cycle after the enable and held until the next read issue.
//   - Read: bus_pause high in cycles N..N+w-1; data in cycle N+w+1.
//   - Write: bus_pause high in cycles N+1..N+w+1; commit at the end of cycle N+w+1.
//  Faults:
//   - Unmapped read: bus_rdata = 32'hFFFF_FFFF and bus_fault=1 in cycle N+1. No pause, no BRAM access.
//   - Write to an RO region or unmapped address: dropped, bus_fault=1 in cycle N+1, no pause.
//  Gfx port:
//   - Independent of the FSM; never stalls.
//   - mem_en_b/mem_addr_b are combinational from gfx_addr.
//   - gfx_rdata is registered from the selected region; unmapped returns 32'hFFFF_FFFF.
//  Collisions:
//   - A bus write and a gfx read to the same word in the same cycle return the old data on gfx (BRAMs configured read-first).
//  Arithmetic:
//   - Offsets are 32-bit unsigned subtracts; addr < base wraps large and therefore misses.
// STRUCTURE
//  gba_mem_pkg holds:
//   - MEM_SIZE_* constants and the mem_size_t typedef.
//   - The default region base/size/ws/ro tables and an fsm_state_t enum.
//   - Function byte_we(addr[1:0], size) -> [3:0].
//  One sub-module: mem_region_decode (addr -> hit, region index, word offset).
//   - Instantiated twice: once for the bus port, once for the gfx port.
// TESTING
//  1 Read IWRAM word, w=0: pause never rises; mem_en_a one-hot in cycle N; rdata matches the BRAM model in N+1.
//  2 Read a region with w=2: bus_pause=1 in N and N+1, 0 in N+2; enable in N+2; data in N+3.
//  3 Halfword write 16'hBEEF at VRAM base+2: pause 1 cycle; mem_we_a=4'b1100; readback gives 32'hBEEF_xxxx, old low half kept.
//  4 Write to BIOS (RO) at 0x0000_0010, then read 0x1000_0000: no mem_we_a; fault pulses in both cases; rdata 32'hFFFF_FFFF.
//  5 Gfx reads OAM while the bus writes palette in the same cycle: gfx_rdata = OAM data, not palette; bus write is unaffected.
//  6 reset_n dropped in WWAIT: outputs go to reset values immediately; no write lands; first request after release is accepted.

Source files
------------

// File: rtl/gba_mem_pkg.sv
// Shared types, default region map and helpers for the GBA memory-region controller.
package gba_mem_pkg;

    typedef logic [1:0] mem_size_t;

    localparam mem_size_t MEM_SIZE_BYTE = 2'd0;
    localparam mem_size_t MEM_SIZE_HALF = 2'd1;
    localparam mem_size_t MEM_SIZE_WORD = 2'd2;

    // Default map, index 0 first: BIOS, IWRAM, palette, VRAM, OAM.
    localparam logic [4:0][31:0] DEF_REGION_BASE = {
        32'h0700_0000, 32'h0600_0000, 32'h0500_0000, 32'h0300_0000, 32'h0000_0000
    };
    localparam logic [4:0][31:0] DEF_REGION_SIZE = {
        32'h0000_0400, 32'h0001_8000, 32'h0000_0400, 32'h0000_8000, 32'h0000_4000
    };
    localparam logic [4:0][2:0] DEF_REGION_WS = {3'd2, 3'd0, 3'd1, 3'd0, 3'd0};
    localparam logic [4:0]      DEF_REGION_RO = 5'b00001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RWAIT,
        ST_WWAIT,
        ST_WRITE
    } fsm_state_t;

    // Byte-lane write enables for an access of the given size at addr[1:0].
    function automatic logic [3:0] byte_we(input logic [1:0] addr_lo, input mem_size_t size);
        logic [3:0] we;
        case (size)
            MEM_SIZE_BYTE: we = 4'b0001 << addr_lo;
            MEM_SIZE_HALF: we = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:       we = 4'b1111;
        endcase
        return we;
    endfunction

endpackage

// File: rtl/mem_region_decode.sv
// Address window decoder: lowest-index hit wins, returns region index and word offset.
module mem_region_decode #(
    parameter int                           NUM_REGIONS = 5,
    parameter int                           MEM_AW      = 16,
    parameter int                           RIDX_W      = 3,
    parameter logic [NUM_REGIONS-1:0][31:0] REGION_BASE = '0,
    parameter logic [NUM_REGIONS-1:0][31:0] REGION_SIZE = '0
) (
    input  logic [31:0]       addr,
    output logic              hit,
    output logic [RIDX_W-1:0] region,
    output logic [MEM_AW-1:0] word_off
);

    logic [31:0] off;

    // Scan from the top so the lowest matching window is the one left standing.
    always_comb begin
        hit      = 1'b0;
        region   = '0;
        word_off = '0;
        off      = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            off = addr - REGION_BASE[i];
            if (off < REGION_SIZE[i]) begin
                hit      = 1'b1;
                region   = RIDX_W'(i);
                word_off = off[MEM_AW+1:2];
            end
        end
    end

endmodule

// File: rtl/mem_region_ctrl.sv
// Memory-region controller: bus port with wait states and RO protection, read-only gfx port.
//
//  state    | meaning
//  ---------+--------------------------------------------------------
//  ST_IDLE  | accept requests; zero-wait reads issue directly
//  ST_RWAIT | read wait states, issue when counter reaches 0
//  ST_WWAIT | write wait states, go to ST_WRITE at counter 0
//  ST_WRITE | commit latched write to the BRAM
module mem_region_ctrl
    import gba_mem_pkg::*;
#(
    parameter int                             NUM_REGIONS = 5,
    parameter int                             MEM_AW      = 16,
    parameter int                             WS_W        = 3,
    parameter logic [NUM_REGIONS-1:0][31:0]   REGION_BASE = DEF_REGION_BASE,
    parameter logic [NUM_REGIONS-1:0][31:0]   REGION_SIZE = DEF_REGION_SIZE,
    parameter logic [NUM_REGIONS-1:0][WS_W-1:0] REGION_WS = DEF_REGION_WS,
    parameter logic [NUM_REGIONS-1:0]         REGION_RO   = DEF_REGION_RO
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      bus_req,
    input  logic [31:0]               bus_addr,
    input  logic [31:0]               bus_wdata,
    input  logic [1:0]                bus_size,
    input  logic                      bus_write,
    output logic [31:0]               bus_rdata,
    output logic                      bus_pause,
    output logic                      bus_fault,
    input  logic [31:0]               gfx_addr,
    output logic [31:0]               gfx_rdata,
    output logic [NUM_REGIONS-1:0]    mem_en_a,
    output logic [3:0]                mem_we_a,
    output logic [MEM_AW-1:0]         mem_addr_a,
    output logic [31:0]               mem_wdata_a,
    input  logic [NUM_REGIONS*32-1:0] mem_rdata_a,
    output logic [NUM_REGIONS-1:0]    mem_en_b,
    output logic [MEM_AW-1:0]         mem_addr_b,
    input  logic [NUM_REGIONS*32-1:0] mem_rdata_b
);

    localparam int RIDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    logic              bus_hit, gfx_hit;
    logic [RIDX_W-1:0] bus_region, gfx_region;
    logic [MEM_AW-1:0] bus_off, gfx_off;
    logic [WS_W-1:0]   bus_ws;
    logic              bus_ro;

    fsm_state_t        state_q, state_d;
    logic [WS_W-1:0]   cnt_q, cnt_d;
    logic [RIDX_W-1:0] reg_q, rd_sel_q, gfx_sel_q, a_sel;
    logic [MEM_AW-1:0] woff_q, a_addr;
    logic [1:0]        waddr_lo_q;
    mem_size_t         wsize_q;
    logic [31:0]       wdata_q, hold_q;
    logic              rd_live_q, fault_q, gfx_hit_q;
    logic              a_en, pause_c, issue_rd, accept_wr, fault_d, miss_rd;
    logic [3:0]        we_c;
    logic [31:0]       rdata_a_arr [NUM_REGIONS];
    logic [31:0]       rdata_b_arr [NUM_REGIONS];

    mem_region_decode #(
        .NUM_REGIONS(NUM_REGIONS), .MEM_AW(MEM_AW), .RIDX_W(RIDX_W),
        .REGION_BASE(REGION_BASE), .REGION_SIZE(REGION_SIZE)
    ) u_bus_decode (
        .addr(bus_addr), .hit(bus_hit), .region(bus_region), .word_off(bus_off)
    );

    mem_region_decode #(
        .NUM_REGIONS(NUM_REGIONS), .MEM_AW(MEM_AW), .RIDX_W(RIDX_W),
        .REGION_BASE(REGION_BASE), .REGION_SIZE(REGION_SIZE)
    ) u_gfx_decode (
        .addr(gfx_addr), .hit(gfx_hit), .region(gfx_region), .word_off(gfx_off)
    );

    assign bus_ws = REGION_WS[bus_region];
    assign bus_ro = REGION_RO[bus_region];

    // Split the flattened BRAM read buses into per-region words.
    always_comb begin
        for (int i = 0; i < NUM_REGIONS; i++) begin
            rdata_a_arr[i] = mem_rdata_a[32*i +: 32];
            rdata_b_arr[i] = mem_rdata_b[32*i +: 32];
        end
    end

    // Next-state and port-A control.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pause_c   = 1'b0;
        a_en      = 1'b0;
        a_sel     = bus_region;
        a_addr    = bus_off;
        we_c      = 4'b0000;
        issue_rd  = 1'b0;
        accept_wr = 1'b0;
        fault_d   = 1'b0;
        miss_rd   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus_req) begin
                    if (!bus_hit || (bus_write && bus_ro)) begin
                        fault_d = 1'b1;
                        miss_rd = !bus_write;
                    end else if (!bus_write) begin
                        if (bus_ws == '0) begin
                            a_en     = 1'b1;
                            issue_rd = 1'b1;
                        end else begin
                            pause_c = 1'b1;
                            cnt_d   = bus_ws - WS_W'(1);
                            state_d = ST_RWAIT;
                        end
                    end else begin
                        accept_wr = 1'b1;
                        if (bus_ws == '0) begin
                            state_d = ST_WRITE;
                        end else begin
                            cnt_d   = bus_ws - WS_W'(1);
                            state_d = ST_WWAIT;
                        end
                    end
                end
            end
            ST_RWAIT: begin
                a_sel = reg_q;
                if (cnt_q != '0) begin
                    pause_c = 1'b1;
                    cnt_d   = cnt_q - WS_W'(1);
                end else begin
                    a_en     = 1'b1;
                    issue_rd = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_WWAIT: begin
                pause_c = 1'b1;
                if (cnt_q != '0) cnt_d = cnt_q - WS_W'(1);
                else             state_d = ST_WRITE;
            end
            ST_WRITE: begin
                pause_c = 1'b1;
                a_sel   = reg_q;
                a_addr  = woff_q;
                a_en    = 1'b1;
                we_c    = byte_we(waddr_lo_q, wsize_q);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is held, including the combinational ones.
    always_comb begin
        mem_en_a = '0;
        mem_en_b = '0;
        if (a_en && reset_n)    mem_en_a[a_sel]      = 1'b1;
        if (gfx_hit && reset_n) mem_en_b[gfx_region] = 1'b1;
        mem_we_a    = reset_n ? we_c : 4'b0000;
        bus_pause   = pause_c & reset_n;
        mem_addr_a  = a_addr;
        mem_addr_b  = gfx_off;
        mem_wdata_a = wdata_q;
        bus_fault   = fault_q;
        bus_rdata   = rd_live_q ? rdata_a_arr[rd_sel_q] : hold_q;
        gfx_rdata   = gfx_hit_q ? rdata_b_arr[gfx_sel_q] : 32'hFFFF_FFFF;
    end

    // FSM state and wait-state counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request latches, read-data hold register and fault pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            reg_q      <= '0;
            woff_q     <= '0;
            waddr_lo_q <= '0;
            wsize_q    <= MEM_SIZE_WORD;
            wdata_q    <= '0;
            rd_live_q  <= 1'b0;
            rd_sel_q   <= '0;
            hold_q     <= 32'hFFFF_FFFF;
            fault_q    <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && bus_req && bus_hit) reg_q <= bus_region;
            if (accept_wr) begin
                woff_q     <= bus_off;
                waddr_lo_q <= bus_addr[1:0];
                wsize_q    <= bus_size;
                wdata_q    <= bus_wdata;
            end
            rd_live_q <= issue_rd;
            if (issue_rd) rd_sel_q <= a_sel;
            if (miss_rd)        hold_q <= 32'hFFFF_FFFF;
            else if (rd_live_q) hold_q <= rdata_a_arr[rd_sel_q];
            fault_q <= fault_d;
        end
    end

    // Gfx read select follows gfx_addr one cycle later, in step with the BRAM output.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gfx_hit_q <= 1'b0;
            gfx_sel_q <= '0;
        end else begin
            gfx_hit_q <= gfx_hit;
            gfx_sel_q <= gfx_region;
        end
    end

endmodule

// File: tb/tb_mem_region_ctrl.sv
// Scoreboard bench for mem_region_ctrl with a read-first BRAM model per region.
module tb_mem_region_ctrl;
    import gba_mem_pkg::*;

    localparam int NR    = 5;
    localparam int WORDS = 24576;

    localparam logic [31:0] TB_BASE [NR] = '{32'h0000_0000, 32'h0300_0000, 32'h0500_0000,
                                             32'h0600_0000, 32'h0700_0000};
    localparam logic [31:0] TB_SIZE [NR] = '{32'h4000, 32'h8000, 32'h400, 32'h18000, 32'h400};
    localparam int          TB_WS   [NR] = '{0, 0, 1, 0, 2};
    localparam bit          TB_RO   [NR] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    logic              clock = 1'b0;
    logic              reset_n;
    logic              bus_req, bus_write;
    logic [31:0]       bus_addr, bus_wdata, gfx_addr;
    logic [1:0]        bus_size;
    logic [31:0]       bus_rdata, gfx_rdata, mem_wdata_a;
    logic              bus_pause, bus_fault;
    logic [NR-1:0]     mem_en_a, mem_en_b;
    logic [3:0]        mem_we_a;
    logic [15:0]       mem_addr_a, mem_addr_b;
    logic [NR*32-1:0]  mem_rdata_a, mem_rdata_b;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] bq[$];
    logic [31:0] gq[$];
    logic [31:0] ref_mem [int];

    mem_region_ctrl dut (
        .clock(clock), .reset_n(reset_n),
        .bus_req(bus_req), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_size(bus_size), .bus_write(bus_write),
        .bus_rdata(bus_rdata), .bus_pause(bus_pause), .bus_fault(bus_fault),
        .gfx_addr(gfx_addr), .gfx_rdata(gfx_rdata),
        .mem_en_a(mem_en_a), .mem_we_a(mem_we_a), .mem_addr_a(mem_addr_a),
        .mem_wdata_a(mem_wdata_a), .mem_rdata_a(mem_rdata_a),
        .mem_en_b(mem_en_b), .mem_addr_b(mem_addr_b), .mem_rdata_b(mem_rdata_b)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] pat(input int r, input int w);
        return {8'(r), 8'hA5, 16'(w) ^ 16'h3C5A};
    endfunction

    // BRAM model: read-first on both ports, byte-lane writes on port A.
    logic [31:0] bram [NR][WORDS];
    logic [31:0] ra [NR];
    logic [31:0] rb [NR];
    bit          bram_init = 1'b0;

    always @(posedge clock) begin
        if (!bram_init) begin
            for (int r = 0; r < NR; r++) begin
                ra[r] = '0;
                rb[r] = '0;
                for (int w = 0; w < WORDS; w++) bram[r][w] = pat(r, w);
            end
            bram_init = 1'b1;
        end
        for (int r = 0; r < NR; r++) begin
            if (mem_en_b[r] && int'(mem_addr_b) < WORDS) rb[r] <= bram[r][mem_addr_b];
            if (mem_en_a[r] && int'(mem_addr_a) < WORDS) begin
                ra[r] <= bram[r][mem_addr_a];
                for (int b = 0; b < 4; b++)
                    if (mem_we_a[b]) bram[r][mem_addr_a][8*b +: 8] = mem_wdata_a[8*b +: 8];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NR; r++) begin
            mem_rdata_a[32*r +: 32] = ra[r];
            mem_rdata_b[32*r +: 32] = rb[r];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit tb_decode(input logic [31:0] a, output int r, output int wo);
        logic [31:0] off;
        r  = 0;
        wo = 0;
        for (int i = 0; i < NR; i++) begin
            off = a - TB_BASE[i];
            if (off < TB_SIZE[i]) begin
                r  = i;
                wo = int'(off >> 2);
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_read(input int r, input int w);
        int k = r * 65536 + w;
        if (ref_mem.exists(k)) return ref_mem[k];
        return pat(r, w);
    endfunction

    task automatic ref_write(input int r, input int w, input logic [31:0] d, input logic [3:0] we);
        logic [31:0] v;
        v = ref_read(r, w);
        for (int b = 0; b < 4; b++) if (we[b]) v[8*b +: 8] = d[8*b +: 8];
        ref_mem[r * 65536 + w] = v;
    endtask

    task automatic pop_chk(input string tag, input bit gfx, input logic [31:0] got);
        logic [31:0] e;
        if (gfx ? (gq.size() == 0) : (bq.size() == 0)) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = gfx ? gq.pop_front() : bq.pop_front();
            chk(tag, got, e);
        end
    endtask

    task automatic bus_read(input string tag, input logic [31:0] addr);
        int r, wo, w;
        bit hit;
        hit = tb_decode(addr, r, wo);
        w   = hit ? TB_WS[r] : 0;
        bq.push_back(hit ? ref_read(r, wo) : 32'hFFFF_FFFF);
        @(posedge clock); #1;
        bus_req = 1'b1; bus_write = 1'b0; bus_addr = addr; bus_size = MEM_SIZE_WORD;
        for (int i = 0; i <= w; i++) begin
            @(negedge clock);
            chk({tag, "_pause"}, 32'(bus_pause), 32'(i < w));
            chk({tag, "_en"}, 32'(mem_en_a), (hit && i == w) ? (32'd1 << r) : 32'd0);
            if (hit && i == w) chk({tag, "_addr"}, 32'(mem_addr_a), 32'(wo));
        end
        @(posedge clock); #1;
        bus_req = 1'b0;
        @(negedge clock);
        pop_chk({tag, "_rdata"}, 1'b0, bus_rdata);
        chk({tag, "_fault"}, 32'(bus_fault), 32'(!hit));
    endtask

    task automatic bus_wr(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] size, input logic [3:0] exp_we,
                          input logic [31:0] gaddr);
        int r, wo, w, gr, gw;
        bit hit, drop, ghit;
        hit  = tb_decode(addr, r, wo);
        drop = !hit || TB_RO[r];
        w    = hit ? TB_WS[r] : 0;
        ghit = tb_decode(gaddr, gr, gw);
        gq.push_back(ghit ? ref_read(gr, gw) : 32'hFFFF_FFFF);
        @(posedge clock); #1;
        bus_req = 1'b1; bus_write = 1'b1; bus_addr = addr; bus_wdata = data;
        bus_size = size; gfx_addr = gaddr;
        @(negedge clock);
        chk({tag, "_pause_n"}, 32'(bus_pause), 32'd0);
        chk({tag, "_en_n"}, 32'(mem_en_a), 32'd0);
        @(posedge clock); #1;
        bus_req = 1'b0; bus_write = 1'b0;
        @(negedge clock);
        chk({tag, "_fault"}, 32'(bus_fault), 32'(drop));
        if (drop) begin
            chk({tag, "_pause"}, 32'(bus_pause), 32'd0);
            chk({tag, "_we"}, 32'(mem_we_a), 32'd0);
            chk({tag, "_en"}, 32'(mem_en_a), 32'd0);
        end else begin
            for (int i = 0; i <= w; i++) begin
                if (i > 0) @(negedge clock);
                chk({tag, "_pause"}, 32'(bus_pause), 32'd1);
                chk({tag, "_we"}, 32'(mem_we_a), (i == w) ? 32'(exp_we) : 32'd0);
                chk({tag, "_en"}, 32'(mem_en_a), (i == w) ? (32'd1 << r) : 32'd0);
                if (i == w) begin
                    chk({tag, "_waddr"}, 32'(mem_addr_a), 32'(wo));
                    chk({tag, "_wdata"}, mem_wdata_a, data);
                end
            end
            ref_write(r, wo, data, exp_we);
        end
        @(negedge clock);
        pop_chk({tag, "_gfx"}, 1'b1, gfx_rdata);
    endtask

    task automatic gfx_read(input string tag, input logic [31:0] addr);
        int r, wo;
        bit hit;
        hit = tb_decode(addr, r, wo);
        gq.push_back(hit ? ref_read(r, wo) : 32'hFFFF_FFFF);
        @(posedge clock); #1;
        gfx_addr = addr;
        @(negedge clock);
        chk({tag, "_en_b"}, 32'(mem_en_b), hit ? (32'd1 << r) : 32'd0);
        if (hit) chk({tag, "_addr_b"}, 32'(mem_addr_b), 32'(wo));
        @(negedge clock);
        pop_chk({tag, "_rdata"}, 1'b1, gfx_rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; bus_req = 1'b1; bus_write = 1'b0; bus_addr = 32'h0300_0000;
        bus_wdata = '0; bus_size = MEM_SIZE_WORD; gfx_addr = 32'h0300_0000;
        #22;
        chk("rst_pause", 32'(bus_pause), 32'd0);
        chk("rst_fault", 32'(bus_fault), 32'd0);
        chk("rst_en_a", 32'(mem_en_a), 32'd0);
        chk("rst_en_b", 32'(mem_en_b), 32'd0);
        chk("rst_we", 32'(mem_we_a), 32'd0);
        chk("rst_rdata", bus_rdata, 32'hFFFF_FFFF);
        chk("rst_gfx", gfx_rdata, 32'hFFFF_FFFF);
        bus_req = 1'b0;
        #10 reset_n = 1'b1;

        bus_read("t1_iwram", 32'h0300_0100);
        bus_read("t1_iwram_last", 32'h0300_7FFC);
        bus_read("t1_iwram_end", 32'h0300_8000);
        bus_read("t2_oam_ws2", 32'h0700_0008);
        bus_read("t2_pal_ws1", 32'h0500_0010);

        bus_wr("t3_vram_half", 32'h0600_0002, 32'hBEEF_0000, MEM_SIZE_HALF, 4'b1100, 32'h0600_0400);
        bus_read("t3_vram_rb", 32'h0600_0000);
        bus_wr("t3_iwram_byte", 32'h0300_0101, 32'h0000_AB00, MEM_SIZE_BYTE, 4'b0010, 32'h0300_0000);
        bus_read("t3_byte_rb", 32'h0300_0100);
        bus_wr("t3_iwram_word", 32'h0300_0200, 32'hCAFE_F00D, MEM_SIZE_WORD, 4'b1111, 32'h0000_0000);
        bus_read("t3_word_rb", 32'h0300_0200);

        bus_wr("t4_bios_ro", 32'h0000_0010, 32'h1111_2222, MEM_SIZE_WORD, 4'b1111, 32'h0000_0010);
        bus_read("t4_unmapped", 32'h1000_0000);
        bus_read("t4_bios_rb", 32'h0000_0010);
        bus_wr("t4_unmapped_wr", 32'h0400_0000, 32'h3333_4444, MEM_SIZE_WORD, 4'b1111, 32'h0700_0000);

        bus_wr("t5_pal_vs_oam", 32'h0500_0020, 32'h5555_AAAA, MEM_SIZE_WORD, 4'b1111, 32'h0700_0020);
        bus_wr("t5_collide", 32'h0500_0024, 32'h0BAD_BEEF, MEM_SIZE_WORD, 4'b1111, 32'h0500_0024);
        bus_read("t5_pal_rb", 32'h0500_0020);
        bus_read("t5_coll_rb", 32'h0500_0024);
        gfx_read("t5_gfx_after", 32'h0500_0024);
        gfx_read("t5_gfx_vram", 32'h0601_7FFC);
        gfx_read("t5_gfx_unmapped", 32'h02FF_FFFC);

        gfx_addr = 32'h0500_0004;
        @(posedge clock); #1;
        bus_req = 1'b1; bus_write = 1'b1; bus_addr = 32'h0500_0004;
        bus_wdata = 32'h1234_5678; bus_size = MEM_SIZE_WORD;
        @(posedge clock); #1;
        bus_req = 1'b0; bus_write = 1'b0;
        @(negedge clock);
        chk("t6_wwait_pause", 32'(bus_pause), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("t6_rst_pause", 32'(bus_pause), 32'd0);
        chk("t6_rst_en_a", 32'(mem_en_a), 32'd0);
        chk("t6_rst_en_b", 32'(mem_en_b), 32'd0);
        chk("t6_rst_we", 32'(mem_we_a), 32'd0);
        chk("t6_rst_rdata", bus_rdata, 32'hFFFF_FFFF);
        chk("t6_rst_gfx", gfx_rdata, 32'hFFFF_FFFF);
        @(posedge clock);
        @(posedge clock);
        #3 reset_n = 1'b1;
        bus_read("t6_no_commit", 32'h0500_0004);
        bus_read("t6_after", 32'h0700_0010);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
